// File: rtl/rans_stream_ctrl.sv
// Sequencing controller for the rans_stream encoder: table load, block start,
// symbol feed and a byte FIFO that collects the encoder's 0/1/2-byte output.
module rans_stream_ctrl #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int RESOLUTION   = 10,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      start_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [RESOLUTION-1:0]     cfg_freq_i,
  input  logic [RESOLUTION-1:0]     cfg_cum_freq_i,
  input  logic                      sym_valid_i,
  output logic                      sym_ready_o,
  input  logic [SYMBOL_WIDTH-1:0]   sym_i,
  input  logic                      sym_last_i,
  output logic                      enc_en_o,
  output logic                      enc_freq_wr_o,
  output logic                      enc_restart_o,
  output logic                      enc_stall_o,
  output logic [SYMBOL_WIDTH-1:0]   enc_freq_addr_o,
  output logic [RESOLUTION-1:0]     enc_freq_o,
  output logic [RESOLUTION-1:0]     enc_cum_freq_o,
  output logic [SYMBOL_WIDTH-1:0]   enc_symb_o,
  input  logic [1:0]                enc_valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0] enc_data_i,
  output logic                      byte_valid_o,
  input  logic                      byte_ready_i,
  output logic [SYMBOL_WIDTH-1:0]   byte_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               byte_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, RESTART, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [SYMBOL_WIDTH-1:0] load_addr;
  logic [2:0]              sh;
  logic                    cap_q;
  logic                    last_taken;
  logic [31:0]             byte_count;

  logic [SYMBOL_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        hi_ptr;
  logic [PTR_W:0]          count;
  logic [PTR_W:0]          free_slots;

  logic       cfg_fire;
  logic       issue;
  logic       capture;
  logic       push_lo;
  logic       push_hi;
  logic [1:0] push_n;
  logic       pop;

  assign cfg_fire = cfg_valid_i && cfg_ready_o;
  assign issue    = sym_valid_i && sym_ready_o;

  // Stage 2 of the shadow pipeline only counts once; a stalled edge leaves it frozen.
  assign capture  = sh[2] && cap_q;
  assign push_lo  = capture && enc_valid_i[0];
  assign push_hi  = capture && enc_valid_i[1];
  assign push_n   = {1'b0, push_lo} + {1'b0, push_hi};
  assign hi_ptr   = wr_ptr + PTR_W'(push_lo);

  assign free_slots   = (PTR_W+1)'(FIFO_DEPTH) - count;
  assign enc_stall_o  = free_slots < (PTR_W+1)'(4);
  assign byte_valid_o = count != '0;
  assign byte_o       = mem[rd_ptr];
  assign pop          = byte_valid_o && byte_ready_i;

  assign enc_en_o        = issue;
  assign enc_symb_o      = sym_i;
  assign enc_freq_addr_o = load_addr;
  assign enc_freq_o      = cfg_freq_i;
  assign enc_cum_freq_o  = cfg_cum_freq_i;
  assign byte_count_o    = byte_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_i) begin
          state_next = LOAD;
        end else if (start_i) begin
          state_next = RESTART;
        end
      end
      LOAD: begin
        if (cfg_fire && (load_addr == '1)) begin
          state_next = IDLE;
        end
      end
      RESTART: state_next = RUN;
      RUN: begin
        if (issue && sym_last_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((sh == 3'b000) && (count == '0)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o   = 1'b0;
    enc_freq_wr_o = 1'b0;
    enc_restart_o = 1'b0;
    sym_ready_o   = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (state)
      IDLE:    busy_o = 1'b0;
      LOAD: begin
        cfg_ready_o   = 1'b1;
        enc_freq_wr_o = cfg_valid_i;
      end
      RESTART: enc_restart_o = 1'b1;
      RUN:     sym_ready_o   = !enc_stall_o && !last_taken;
      DONE:    done_o        = 1'b1;
      default: ;
    endcase
  end

  // Shadow of the encoder's enable pipeline plus per-block bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_addr  <= '0;
      sh         <= '0;
      cap_q      <= 1'b0;
      last_taken <= 1'b0;
      byte_count <= '0;
    end else begin
      if (cfg_fire) begin
        load_addr <= load_addr + SYMBOL_WIDTH'(1);
      end
      if (state == RESTART) begin
        sh         <= '0;
        cap_q      <= 1'b0;
        last_taken <= 1'b0;
        byte_count <= '0;
      end else begin
        if (!enc_stall_o) begin
          sh <= {sh[1:0], issue};
        end
        cap_q <= !enc_stall_o;
        if (issue && sym_last_i) begin
          last_taken <= 1'b1;
        end
        byte_count <= byte_count + 32'(push_n);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop);
    end
  end

  // Lower encoder byte is written first so it leaves the FIFO first.
  always_ff @(posedge clk_i) begin
    if (push_lo) begin
      mem[wr_ptr] <= enc_data_i[SYMBOL_WIDTH-1:0];
    end
    if (push_hi) begin
      mem[hi_ptr] <= enc_data_i[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH];
    end
  end

endmodule

// File: tb/tb_rans_stream_ctrl.sv
// Testbench for rans_stream_ctrl: a behavioural 3-stage rANS encoder drives the
// DUT, and the popped byte stream is compared with a per-block golden encoding.
module tb_rans_stream_ctrl;

  localparam int SW    = 8;
  localparam int RES   = 10;
  localparam int DEPTH = 16;
  localparam logic [31:0] RANS_L = 32'h0080_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            load, start;
  logic            cfg_valid, cfg_ready;
  logic [RES-1:0]  cfg_freq, cfg_cum;
  logic            sym_valid, sym_ready, sym_last;
  logic [SW-1:0]   sym;
  logic            enc_en, enc_freq_wr, enc_restart, enc_stall;
  logic [SW-1:0]   enc_freq_addr, enc_symb;
  logic [RES-1:0]  enc_freq, enc_cum;
  logic [1:0]      enc_valid;
  logic [2*SW-1:0] enc_data;
  logic            byte_valid, byte_ready;
  logic [SW-1:0]   byte_out;
  logic            busy, done;
  logic [31:0]     byte_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rans_stream_ctrl #(.SYMBOL_WIDTH(SW), .RESOLUTION(RES), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .start_i(start),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_freq_i(cfg_freq), .cfg_cum_freq_i(cfg_cum),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready), .sym_i(sym), .sym_last_i(sym_last),
    .enc_en_o(enc_en), .enc_freq_wr_o(enc_freq_wr), .enc_restart_o(enc_restart),
    .enc_stall_o(enc_stall), .enc_freq_addr_o(enc_freq_addr),
    .enc_freq_o(enc_freq), .enc_cum_freq_o(enc_cum), .enc_symb_o(enc_symb),
    .enc_valid_i(enc_valid), .enc_data_i(enc_data),
    .byte_valid_o(byte_valid), .byte_ready_i(byte_ready), .byte_o(byte_out),
    .busy_o(busy), .done_o(done), .byte_count_o(byte_count)
  );

  // One byte-wise rANS step: renormalise (low byte first), then fold the symbol in.
  function automatic void rans_step(input logic [31:0] x_in, input int f_in, input int c,
                                    output logic [31:0] x_out, output int n,
                                    output logic [15:0] b);
    logic [31:0] x;
    logic [31:0] xmax;
    int f;
    f    = (f_in == 0) ? 1 : f_in;
    x    = x_in;
    xmax = ((RANS_L >> RES) << 8) * 32'(f);
    n    = 0;
    b    = '0;
    while (x >= xmax && n < 2) begin
      b[n*8 +: 8] = x[7:0];
      x = x >> 8;
      n++;
    end
    x_out = ((x / 32'(f)) << RES) + (x % 32'(f)) + 32'(c);
  endfunction

  logic [RES-1:0] enc_tbl_f [256];
  logic [RES-1:0] enc_tbl_c [256];
  logic [31:0]    enc_x, nx;
  int             nn;
  logic [15:0]    nb;
  logic [2:0]     pv;
  logic [1:0]     pn [3];
  logic [15:0]    pd [3];

  always_comb rans_step(enc_x, int'(enc_tbl_f[enc_symb]), int'(enc_tbl_c[enc_symb]), nx, nn, nb);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv    <= '0;
      enc_x <= RANS_L;
    end else begin
      if (enc_freq_wr) begin
        enc_tbl_f[enc_freq_addr] <= enc_freq;
        enc_tbl_c[enc_freq_addr] <= enc_cum;
      end
      if (enc_restart) begin
        pv    <= '0;
        enc_x <= RANS_L;
      end else if (!enc_stall) begin
        pv    <= {pv[1:0], enc_en};
        pn[0] <= 2'(nn);
        pn[1] <= pn[0];
        pn[2] <= pn[1];
        pd[0] <= nb;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        if (enc_en) enc_x <= nx;
      end
    end
  end

  // Garbage valid flags while stage 2 is empty must be ignored by the controller.
  assign enc_valid = !pv[2] ? 2'b11 : (pn[2] == 2'd2) ? 2'b11 : (pn[2] == 2'd1) ? 2'b01 : 2'b00;
  assign enc_data  = pv[2] ? pd[2] : 16'hA55A;

  int         cfg_f [256];
  int         cfg_c [256];
  int         tbl_f [256];
  int         tbl_c [256];
  logic [7:0] blk[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got[$];
  int         exp_max_n;

  int acc_idx, beat_cnt, wr_cnt, wr_bad, restarts, en_early, dones, busy_cyc;
  int stall_seen, popped, max_occ, max_delta;
  int prev_bc = 0;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) begin
      got.push_back(byte_out);
      popped++;
    end
    if (sym_valid && sym_ready) acc_idx++;
    if (cfg_valid && cfg_ready) beat_cnt++;
    if (enc_restart) restarts++;
    if (enc_en && restarts == 0) en_early++;
    if (done) dones++;
    if (busy) busy_cyc++;
    if (enc_stall) stall_seen++;
    if (enc_freq_wr) begin
      if (int'(enc_freq_addr) != (wr_cnt % 256) || int'(enc_freq) != cfg_f[wr_cnt % 256] ||
          int'(enc_cum) != cfg_c[wr_cnt % 256])
        wr_bad++;
      wr_cnt++;
    end
    if (int'(byte_count) >= prev_bc && int'(byte_count) - prev_bc > max_delta)
      max_delta = int'(byte_count) - prev_bc;
    prev_bc = int'(byte_count);
    if (busy && !enc_restart && int'(byte_count) - popped > max_occ)
      max_occ = int'(byte_count) - popped;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build_golden();
    logic [31:0] x, xn;
    int n;
    logic [15:0] b;
    x = RANS_L;
    exp_bytes.delete();
    exp_max_n = 0;
    foreach (blk[i]) begin
      rans_step(x, tbl_f[blk[i]], tbl_c[blk[i]], xn, n, b);
      for (int k = 0; k < n; k++) exp_bytes.push_back(b[k*8 +: 8]);
      if (n > exp_max_n) exp_max_n = n;
      x = xn;
    end
  endtask

  task automatic make_block(input int n, input int kind);
    blk.delete();
    for (int i = 0; i < n; i++) begin
      if (kind == 0) blk.push_back(8'($urandom_range(0, 255)));
      else if ($urandom_range(0, 3) == 0) blk.push_back(8'($urandom_range(2, 255)));
      else blk.push_back(8'($urandom_range(0, 1)));
    end
    build_golden();
  endtask

  task automatic apply_stimulus_load(input bit with_start, input bit full_rate);
    wr_cnt = 0; beat_cnt = 0; wr_bad = 0; restarts = 0;
    @(posedge clk); #1;
    load = 1'b1; start = with_start;
    busy_cyc = 0;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    for (int c = 0; c < 3000 && beat_cnt < 256; c++) begin
      cfg_valid = full_rate || ($urandom_range(0, 3) != 0);
      cfg_freq  = RES'(cfg_f[beat_cnt % 256]);
      cfg_cum   = RES'(cfg_c[beat_cnt % 256]);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
  endtask

  // mode 0: byte_ready high; 1: random valid/ready; 2: ready held low for 80 cycles.
  task automatic apply_stimulus_block(input string name, input int mode);
    int n, first_ready, snap, mism;
    n = blk.size(); first_ready = -1; snap = 0; mism = 0;
    got.delete();
    acc_idx = 0; popped = 0; dones = 0; restarts = 0; en_early = 0;
    max_delta = 0; max_occ = 0; stall_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 4000 && dones == 0; c++) begin
      if (c == 1) start = 1'b0;
      sym_valid = (acc_idx < n) && (mode != 1 || $urandom_range(0, 4) != 0);
      sym       = (acc_idx < n) ? blk[acc_idx] : 8'h00;
      sym_last  = (acc_idx == n - 1);
      byte_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (c >= 80);
      #3;
      if (first_ready < 0 && sym_ready) first_ready = c;
      if (mode == 2 && c == 70) snap = acc_idx;
      if (mode == 2 && c == 79) begin
        check_output({name, "_stall_high"}, 64'(enc_stall), 64'(1));
        check_output({name, "_issue_frozen"}, 64'(acc_idx), 64'(snap));
      end
      @(posedge clk); #1;
    end
    sym_valid = 1'b0; sym_last = 1'b0; byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < exp_bytes.size(); i++)
      if (i >= got.size() || got[i] !== exp_bytes[i]) mism++;
    check_output({name, "_done_pulses"}, 64'(dones), 64'(1));
    check_output({name, "_restart_pulses"}, 64'(restarts), 64'(1));
    check_output({name, "_en_before_restart"}, 64'(en_early), 64'(0));
    check_output({name, "_first_ready_cycle"}, 64'(first_ready), 64'(2));
    check_output({name, "_byte_count"}, 64'(byte_count), 64'(exp_bytes.size()));
    check_output({name, "_bytes_out"}, 64'(got.size()), 64'(exp_bytes.size()));
    check_output({name, "_byte_mismatches"}, 64'(mism), 64'(0));
    check_output({name, "_max_bytes_per_capture"}, 64'(max_delta), 64'(exp_max_n));
    check_output({name, "_occupancy_le_depth"}, 64'(max_occ <= DEPTH), 64'(1));
    check_output({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic check_output_reset(input string name);
    check_output({name, "_busy"}, 64'(busy), 64'(0));
    check_output({name, "_byte_valid"}, 64'(byte_valid), 64'(0));
    check_output({name, "_stall"}, 64'(enc_stall), 64'(0));
    check_output({name, "_done"}, 64'(done), 64'(0));
    check_output({name, "_byte_count"}, 64'(byte_count), 64'(0));
  endtask

  initial begin
    int cum;
    bit reached;
    rst = 1'b0; load = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_freq = '0; cfg_cum = '0;
    sym_valid = 1'b0; sym = '0; sym_last = 1'b0; byte_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_output_reset("reset");
    check_output("reset_cfg_ready", 64'(cfg_ready), 64'(0));
    check_output("reset_restart", 64'(enc_restart), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] table load with freq=k cum=2k at full rate");
    for (int k = 0; k < 256; k++) begin
      cfg_f[k] = k;
      cfg_c[k] = 2 * k;
    end
    apply_stimulus_load(1'b0, 1'b1);
    check_output("load1_busy_after", 64'(busy), 64'(0));
    check_output("load1_writes", 64'(wr_cnt), 64'(256));
    check_output("load1_bad_writes", 64'(wr_bad), 64'(0));
    check_output("load1_busy_cycles", 64'(busy_cyc), 64'(256));

    $display("[TB] real table load with load_i and start_i together");
    cum = 0;
    for (int k = 0; k < 256; k++) begin
      tbl_f[k] = (k == 0) ? 1 : (k == 1) ? 7 : 4;
      tbl_c[k] = cum;
      cum += tbl_f[k];
      cfg_f[k] = tbl_f[k];
      cfg_c[k] = tbl_c[k];
    end
    apply_stimulus_load(1'b1, 1'b0);
    check_output("load2_busy_after", 64'(busy), 64'(0));
    check_output("load2_writes", 64'(wr_cnt), 64'(256));
    check_output("load2_bad_writes", 64'(wr_bad), 64'(0));
    check_output("load2_no_restart", 64'(restarts), 64'(0));

    $display("[TB] encoding blocks");
    make_block(100, 0);
    apply_stimulus_block("blk100", 0);
    make_block(60, 1);
    apply_stimulus_block("two_byte", 0);
    make_block(100, 0);
    apply_stimulus_block("backpressure", 2);
    check_output("backpressure_stall_seen", 64'(stall_seen > 0), 64'(1));
    make_block(80, 1);
    apply_stimulus_block("random_hs", 1);

    $display("[TB] reset in the middle of a block");
    make_block(40, 0);
    reached = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (c == 1) start = 1'b0;
      sym_valid = 1'b1;
      sym = blk[acc_idx % 40];
      sym_last = 1'b0;
      byte_ready = 1'b0;
      #3;
      if (c >= 3 && byte_count >= 32'd5) reached = 1'b1;
      @(posedge clk); #1;
    end
    check_output("midrst_fifo_filled", 64'(reached), 64'(1));
    rst = 1'b1;
    #1;
    check_output_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0; sym_valid = 1'b0; byte_ready = 1'b1;
    make_block(60, 0);
    apply_stimulus_block("after_reset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
